// File: rtl/cpwm_deadtime_gen_pkg.sv
// Shared types and decode helpers for the CPWM dead-time generator.
// A leg's gate and dead-time outputs are pure functions of its state.
package cpwm_pkg;

   localparam int N_LEGS_DEF   = 3;
   localparam int DT_WIDTH_DEF = 10;

   typedef enum logic [2:0] {
      OFF  = 3'd0,
      DT_H = 3'd1,
      ON_H = 3'd2,
      DT_L = 3'd3,
      ON_L = 3'd4
   } leg_state_t;

   // Returns {gate_h, gate_l}; only the ON states drive a gate, and never both.
   function automatic logic [1:0] leg_gates(input leg_state_t s);
      logic [1:0] g;
      g = 2'b00;
      case (s)
         ON_H:    g = 2'b10;
         ON_L:    g = 2'b01;
         default: g = 2'b00;
      endcase
      return g;
   endfunction

   function automatic logic leg_in_dt(input leg_state_t s);
      return (s == DT_H) || (s == DT_L);
   endfunction

endpackage

// File: rtl/cpwm_deadtime_gen_if.sv
// Configuration, raw PWM and gate-driver signals of the dead-time generator.
// master = the side producing config/PWM; slave = the generator itself.
interface cpwm_deadtime_gen_if #(
   parameter int N_LEGS   = cpwm_pkg::N_LEGS_DEF,
   parameter int DT_WIDTH = cpwm_pkg::DT_WIDTH_DEF
);
   logic                en;
   logic [DT_WIDTH-1:0] dt_cycles;
   logic [N_LEGS-1:0]   pwm_in;
   logic                fault_n;
   logic                fault_clr;
   logic [N_LEGS-1:0]   gate_h;
   logic [N_LEGS-1:0]   gate_l;
   logic [N_LEGS-1:0]   dt_active;
   logic                fault_latched;

   modport master (
      output en, dt_cycles, pwm_in, fault_n, fault_clr,
      input  gate_h, gate_l, dt_active, fault_latched
   );

   modport slave (
      input  en, dt_cycles, pwm_in, fault_n, fault_clr,
      output gate_h, gate_l, dt_active, fault_latched
   );
endinterface

// File: rtl/cpwm_deadtime_gen_dt_leg.sv
// One half-bridge leg: state machine, dead-time counter and registered gate outputs.
// Outputs are registered from the next state so a gate changes on the same edge as the state.
module cpwm_dt_leg
   import cpwm_pkg::*;
#(
   parameter int DT_WIDTH = DT_WIDTH_DEF
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   input  logic                run_i,
   input  logic                kill_i,
   input  logic                pwm_i,
   input  logic [DT_WIDTH-1:0] dt_cycles_i,
   output logic                gate_h_o,
   output logic                gate_l_o,
   output logic                dt_active_o
);

   leg_state_t          state_q, state_d;
   logic [DT_WIDTH-1:0] cnt_q, cnt_d;
   logic [DT_WIDTH-1:0] dt_load;
   logic                gate_h_q, gate_h_d;
   logic                gate_l_q, gate_l_d;
   logic                dt_active_q, dt_active_d;
   logic [1:0]          gates;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q     <= OFF;
         cnt_q       <= '0;
         gate_h_q    <= 1'b0;
         gate_l_q    <= 1'b0;
         dt_active_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         gate_h_q    <= gate_h_d;
         gate_l_q    <= gate_l_d;
         dt_active_q <= dt_active_d;
      end
   end

   always_comb begin
      dt_load = (dt_cycles_i == '0) ? DT_WIDTH'(1) : dt_cycles_i;
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!run_i) begin
         state_d = OFF;
         cnt_d   = '0;
      end else begin
         case (state_q)
            OFF: begin
               state_d = pwm_i ? DT_H : DT_L;
               cnt_d   = dt_load;
            end
            // A pulse that ends inside the dead time never raised H, so L may return at once.
            DT_H: begin
               if (!pwm_i)                         state_d = ON_L;
               else if (cnt_q == DT_WIDTH'(1))     state_d = ON_H;
               else                                cnt_d   = cnt_q - DT_WIDTH'(1);
            end
            ON_H: begin
               if (!pwm_i) begin
                  state_d = DT_L;
                  cnt_d   = dt_load;
               end
            end
            DT_L: begin
               if (pwm_i)                          state_d = ON_H;
               else if (cnt_q == DT_WIDTH'(1))     state_d = ON_L;
               else                                cnt_d   = cnt_q - DT_WIDTH'(1);
            end
            ON_L: begin
               if (pwm_i) begin
                  state_d = DT_H;
                  cnt_d   = dt_load;
               end
            end
            default: begin
               state_d = OFF;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // kill_i comes straight from the fault latch input so gates drop one edge after the fault.
   always_comb begin
      gates       = leg_gates(state_d);
      gate_h_d    = gates[1] & ~kill_i;
      gate_l_d    = gates[0] & ~kill_i;
      dt_active_d = leg_in_dt(state_d);
   end

   assign gate_h_o    = gate_h_q;
   assign gate_l_o    = gate_l_q;
   assign dt_active_o = dt_active_q;

endmodule

// File: rtl/cpwm_deadtime_gen.sv
// Dead-time generator top: registers raw PWM, holds the sticky fault latch and the run gate,
// and instantiates one cpwm_dt_leg per half-bridge leg.
module cpwm_deadtime_gen
   import cpwm_pkg::*;
#(
   parameter int N_LEGS   = N_LEGS_DEF,
   parameter int DT_WIDTH = DT_WIDTH_DEF
) (
   input  logic                 ACLK,
   input  logic                 ARESETN,
   cpwm_deadtime_gen_if.slave   bus
);

   logic [N_LEGS-1:0] pwm_q, pwm_d;
   logic              fault_q, fault_d;
   logic              run;
   logic [N_LEGS-1:0] gate_h, gate_l, dt_active;

   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         pwm_q   <= '0;
         fault_q <= 1'b0;
      end else begin
         pwm_q   <= pwm_d;
         fault_q <= fault_d;
      end
   end

   // An active fault always wins over a simultaneous clear request.
   always_comb begin
      pwm_d   = bus.pwm_in;
      fault_d = fault_q;
      if (!bus.fault_n)
         fault_d = 1'b1;
      else if (bus.fault_clr)
         fault_d = 1'b0;
   end

   assign run = bus.en & ~fault_q;

   for (genvar i = 0; i < N_LEGS; i++) begin : g_leg
      cpwm_dt_leg #(
         .DT_WIDTH (DT_WIDTH)
      ) u_leg (
         .clk_i       (ACLK),
         .rst_n_i     (ARESETN),
         .run_i       (run),
         .kill_i      (fault_d),
         .pwm_i       (pwm_q[i]),
         .dt_cycles_i (bus.dt_cycles),
         .gate_h_o    (gate_h[i]),
         .gate_l_o    (gate_l[i]),
         .dt_active_o (dt_active[i])
      );
   end

   assign bus.gate_h        = gate_h;
   assign bus.gate_l        = gate_l;
   assign bus.dt_active     = dt_active;
   assign bus.fault_latched = fault_q;

endmodule

// File: tb/tb_cpwm_deadtime_gen.sv
// Directed bench for cpwm_deadtime_gen: latency, short pulses, minimum dead time,
// fault latch, dead-time resampling, random shoot-through sweep and mid-dead-time reset.
module tb_cpwm_deadtime_gen;

   localparam int NL = 3;
   localparam int DW = 10;

   logic clk;
   logic rstn;
   int   checks;
   int   errors;

   cpwm_deadtime_gen_if #(.N_LEGS(NL), .DT_WIDTH(DW)) bus ();

   cpwm_deadtime_gen #(.N_LEGS(NL), .DT_WIDTH(DW)) dut (
      .ACLK    (clk),
      .ARESETN (rstn),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Every clock also verifies that no leg drives both gates.
   task automatic tick();
      @(posedge clk);
      #1;
      checks++;
      assert ((bus.gate_h & bus.gate_l) === 3'b000) else begin
         errors++;
         $error("FAIL shoot_through observed_h=%0h observed_l=%0h expected_overlap=0",
                bus.gate_h, bus.gate_l);
      end
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   initial begin
      checks         = 0;
      errors         = 0;
      rstn           = 1'b0;
      bus.en         = 1'b0;
      bus.dt_cycles  = 10'd5;
      bus.pwm_in     = 3'b000;
      bus.fault_n    = 1'b1;
      bus.fault_clr  = 1'b0;
      ticks(2);
      chk("rst_gate_h", bus.gate_h, 3'b000);
      chk("rst_gate_l", bus.gate_l, 3'b000);
      chk("rst_dt_active", bus.dt_active, 3'b000);
      chk("rst_fault", bus.fault_latched, 1'b0);

      // 1: dt=5, rising pwm on leg 0
      rstn   = 1'b1;
      bus.en = 1'b1;
      ticks(12);
      chk("t1_start_l", bus.gate_l, 3'b111);
      chk("t1_start_h", bus.gate_h, 3'b000);
      bus.pwm_in = 3'b001;
      tick();
      chk("t1_l_t1", bus.gate_l[0], 1'b1);
      for (int c = 2; c <= 6; c++) begin
         tick();
         chk("t1_dt_active", bus.dt_active[0], 1'b1);
         chk("t1_l_low", bus.gate_l[0], 1'b0);
         chk("t1_h_low", bus.gate_h[0], 1'b0);
      end
      tick();
      chk("t1_h_t7", bus.gate_h[0], 1'b1);
      chk("t1_dt_t7", bus.dt_active[0], 1'b0);

      // 2: dt=10, 3-cycle pulse never reaches H
      bus.dt_cycles = 10'd10;
      bus.pwm_in    = 3'b000;
      ticks(14);
      chk("t2_pre_l", bus.gate_l, 3'b111);
      for (int c = 0; c < 10; c++) begin
         bus.pwm_in[0] = (c < 3);
         chk("t2_h_never", bus.gate_h[0], 1'b0);
         chk("t2_l", bus.gate_l[0], (c >= 2 && c <= 4) ? 1'b0 : 1'b1);
         tick();
      end

      // 3: dt=0 behaves as one cycle
      bus.dt_cycles = 10'd0;
      bus.pwm_in    = 3'b001;
      ticks(2);
      chk("t3_rise_dt", bus.dt_active[0], 1'b1);
      chk("t3_rise_gates", {bus.gate_h[0], bus.gate_l[0]}, 2'b00);
      tick();
      chk("t3_rise_h", bus.gate_h[0], 1'b1);
      bus.pwm_in = 3'b000;
      ticks(2);
      chk("t3_fall_dt", bus.dt_active[0], 1'b1);
      chk("t3_fall_gates", {bus.gate_h[0], bus.gate_l[0]}, 2'b00);
      tick();
      chk("t3_fall_l", bus.gate_l[0], 1'b1);
      bus.pwm_in = 3'b001;
      ticks(3);
      chk("t3_on_h", bus.gate_h, 3'b001);

      // 4: fault latch, ignored clear, real clear, restart with full dead time
      bus.fault_n = 1'b0;
      tick();
      bus.fault_n = 1'b1;
      chk("t4_fault_h", bus.gate_h, 3'b000);
      chk("t4_fault_l", bus.gate_l, 3'b000);
      chk("t4_latched", bus.fault_latched, 1'b1);
      ticks(3);
      chk("t4_sticky", bus.fault_latched, 1'b1);
      chk("t4_sticky_h", bus.gate_h, 3'b000);
      bus.fault_clr = 1'b1;
      bus.fault_n   = 1'b0;
      tick();
      bus.fault_clr = 1'b0;
      bus.fault_n   = 1'b1;
      tick();
      chk("t4_clr_ignored", bus.fault_latched, 1'b1);
      bus.dt_cycles = 10'd3;
      bus.fault_clr = 1'b1;
      tick();
      bus.fault_clr = 1'b0;
      chk("t4_cleared", bus.fault_latched, 1'b0);
      chk("t4_off_gates", {bus.gate_h, bus.gate_l}, 6'b000000);
      tick();
      chk("t4_restart_dt", bus.dt_active, 3'b111);
      chk("t4_restart_h", bus.gate_h, 3'b000);
      ticks(2);
      chk("t4_dt_end", bus.dt_active, 3'b111);
      tick();
      chk("t4_on_h", bus.gate_h, 3'b001);
      chk("t4_on_l", bus.gate_l, 3'b110);

      // 5: dt change during a dead time applies only to the next one
      for (int c = 0; c <= 22; c++) begin
         if (c == 0) begin
            bus.pwm_in    = 3'b000;
            bus.dt_cycles = 10'd20;
         end
         if (c == 3) bus.dt_cycles = 10'd2;
         if (c == 21) begin
            chk("t5_still_dt", bus.dt_active[0], 1'b1);
            chk("t5_l_low", bus.gate_l[0], 1'b0);
         end
         if (c == 22) chk("t5_l_on", bus.gate_l[0], 1'b1);
         tick();
      end
      bus.pwm_in = 3'b001;
      ticks(3);
      chk("t5_new_dt", bus.dt_active[0], 1'b1);
      chk("t5_new_h_low", bus.gate_h[0], 1'b0);
      tick();
      chk("t5_new_h_on", bus.gate_h[0], 1'b1);

      // 6: enable drop, random sweep, reset in the middle of a dead time
      bus.en = 1'b0;
      tick();
      chk("t6_en_off", {bus.gate_h, bus.gate_l}, 6'b000000);
      bus.en = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         bus.pwm_in    = 3'($urandom);
         bus.dt_cycles = 10'($urandom_range(0, 6));
         bus.en        = ($urandom_range(0, 15) != 0);
         bus.fault_n   = ($urandom_range(0, 63) != 0);
         bus.fault_clr = ($urandom_range(0, 7) == 0);
         tick();
      end
      bus.en        = 1'b1;
      bus.fault_n   = 1'b1;
      bus.fault_clr = 1'b1;
      bus.pwm_in    = 3'b000;
      bus.dt_cycles = 10'd15;
      tick();
      bus.fault_clr = 1'b0;
      ticks(20);
      chk("t6_settled_l", bus.gate_l, 3'b111);
      bus.pwm_in = 3'b111;
      ticks(4);
      chk("t6_in_dt", bus.dt_active, 3'b111);
      rstn = 1'b0;
      tick();
      chk("t6_rst_h", bus.gate_h, 3'b000);
      chk("t6_rst_l", bus.gate_l, 3'b000);
      chk("t6_rst_dt", bus.dt_active, 3'b000);
      chk("t6_rst_fault", bus.fault_latched, 1'b0);
      rstn = 1'b1;
      tick();
      chk("t6_restart_dt", bus.dt_active, 3'b111);
      chk("t6_restart_gates", {bus.gate_h, bus.gate_l}, 6'b000000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
